iir_filter: RTL and testbench
=============================

// Module: iir_filter
// PURPOSE
//  Fixed-point 8th-order IIR low-pass filter: four cascaded direct-form-I biquads, one shared MAC.
//  Coefficients are loaded at runtime through a write port. One new input sample every
//  SAMPLE_CLKS clocks; one filtered output per sample. Sits between the sample source and the downstream DSP.
// PARAMETERS
//  SAMPLE_CLKS  52  clocks per sample period (internal sample-rate divider)
//  NUM_SECT     4   biquad sections; 5*NUM_SECT coefficients
// PORTS
//  clk     in   1   system clock, all logic on rising edge
//  nrst    in   1   reset: synchronous, active-high (asserted when nrst=1)
//  c_we    in   1   coefficient write enable; 1 = load mode, filter idle
//  c_in    in   16  coefficient data, signed Q2.14
//  c_addr  in   5   coefficient address 0..19
//  din     in   16  input sample, signed Q1.15, held stable by source for a sample period
//  dout    out  24  filtered sample, signed Q1.23, registered
// BEHAVIOUR
//  - Reset (nrst=1 at clk edge): dout=0, all delay lines=0, coefficient RAM=0, phase counter=0.
//  - Coef map: addr=5*s+k, s=section 0..3, k: 0=b0 1=b1 2=b2 3=a1 4=a2.
//    c_we=1: coef[c_addr]<=c_in each clock; c_addr>=20 ignored. Phase counter held at 0, states/dout held.
//  - c_we=0: phase counter runs 0..SAMPLE_CLKS-1, wraps. At phase 0, din is latched into Q1.23 (din<<8).
//  - Section s: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2; x of s>0 is y of s-1.
//    Phases 1+6s..5+6s: one MAC each; phase 6+6s: round, saturate, shift delay lines.
//    Products 24x16 signed; 48-bit accumulator; result = acc >>> 14 rounded half-up
//    (add 1<<13 first), saturated to [0x800000, 0x7FFFFF].
//  - dout updated at phase 25 with section-3 output; held otherwise. Latency: din latched
//    at phase 0 appears on dout 25 clocks later.
//  - din changes at other phases are ignored. A c_we rising mid-period aborts the current
//    computation: counter to 0, dout and states keep last committed values.
//  - Coefficient write and filter compute are never simultaneous (c_we gates both).
// STRUCTURE
//  - Package iir_pkg: widths (DATA_W=24, COEF_W=16, IN_W=16, ACC_W=48, FRAC=14),
//    NUM_SECT, coefficient index constants B0..A2, sat/round function.
//  - One sub-module iir_mac: signed multiply-accumulate with clear, round and saturate.
//  - Top: coefficient RAM (20x16), delay-line registers (4 sections x x1,x2,y1,y2),
//    phase counter, sequencer.
// TESTING
//  - Reset then idle: dout=0x000000 through 10 periods with din=0.
//  - Pass-through: b0=0x4000 every section, rest 0; impulse din=0x8000 -> dout=0x800000
//    one period, then 0x000000.
//  - Recursion: sec0 b0=0x4000, a1=0xE000 (-0.5), others pass-through; impulse 0x8000
//    -> 0x800000, 0xC00000, 0xE00000, 0xF00000, ...
//  - Saturation: sec0 b0=0x4000, a1=0xC000 (-1.0); step din=0x7FFF -> dout climbs,
//    clamps at 0x7FFFFF, no wrap.
//  - Write at c_addr=20..31 leaves coefficients 0..19 unchanged (re-run pass-through check).
//  - nrst=1 mid-period: next clock dout=0, states cleared; after reload, impulse response repeats exactly.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared widths, coefficient map and the round/saturate helper for the
// four-section biquad IIR filter.
package iir_pkg;
    localparam int DATA_W     = 24;
    localparam int COEF_W     = 16;
    localparam int IN_W       = 16;
    localparam int ACC_W      = 48;
    localparam int FRAC       = 14;
    localparam int PROD_W     = DATA_W + COEF_W;
    localparam int NUM_SECT   = 4;
    localparam int NUM_COEF   = 5 * NUM_SECT;
    localparam int SECT_CLKS  = 6;
    localparam int MAC_STEPS  = 5;

    localparam int B0 = 0;
    localparam int B1 = 1;
    localparam int B2 = 2;
    localparam int A1 = 3;
    localparam int A2 = 4;

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = -SAT_MAX - ACC_W'(1);

    // Q3.37 accumulator back to Q1.23: round half-up, then clamp.
    function automatic logic signed [DATA_W-1:0] sat_round(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] t;
        t = (acc + RND_HALF) >>> FRAC;
        if (t > SAT_MAX) begin
            t = SAT_MAX;
        end else if (t < SAT_MIN) begin
            t = SAT_MIN;
        end
        return t[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/iir_mac.sv
// Signed 24x16 multiply-accumulate; clr starts a fresh sum with this product,
// neg subtracts it. The rounded, saturated accumulator is always on result.
module iir_mac
    import iir_pkg::*;
(
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     neg,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [DATA_W-1:0] result
);
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

    always_comb begin
        prod     = a * b;
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        base     = clr ? '0 : acc_q;
        acc_d    = acc_q;
        if (en) begin
            acc_d = neg ? (base - prod_ext) : (base + prod_ext);
        end
        result = sat_round(acc_q);
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/iir_filter.sv
// 8th-order IIR low-pass: four direct-form-I biquads time-shared on one MAC,
// sequenced by a free-running phase counter over each sample period.
module iir_filter
    import iir_pkg::*;
#(
    parameter int SAMPLE_CLKS = 52
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              c_we,
    input  logic [COEF_W-1:0] c_in,
    input  logic [4:0]        c_addr,
    input  logic [IN_W-1:0]   din,
    output logic [DATA_W-1:0] dout
);
    localparam int SECT_W = $clog2(NUM_SECT);
    localparam int PH_W   = $clog2(SAMPLE_CLKS);
    localparam logic [PH_W-1:0] PH_LAST     = PH_W'(SAMPLE_CLKS - 1);
    localparam logic [PH_W-1:0] PH_CALC_END = PH_W'(SECT_CLKS * NUM_SECT);
    localparam logic [PH_W-1:0] PH_OUT      = PH_W'(SECT_CLKS * NUM_SECT + 1);

    logic [PH_W-1:0]          phase_q, phase_d;
    logic [2:0]               step_q, step_d;
    logic [SECT_W-1:0]        sect_q, sect_d;
    logic signed [COEF_W-1:0] coef_q [NUM_COEF];
    logic signed [COEF_W-1:0] coef_d [NUM_COEF];
    logic signed [DATA_W-1:0] x1_q [NUM_SECT], x1_d [NUM_SECT];
    logic signed [DATA_W-1:0] x2_q [NUM_SECT], x2_d [NUM_SECT];
    logic signed [DATA_W-1:0] y1_q [NUM_SECT], y1_d [NUM_SECT];
    logic signed [DATA_W-1:0] y2_q [NUM_SECT], y2_d [NUM_SECT];
    logic signed [DATA_W-1:0] x_cur_q, x_cur_d;
    logic [DATA_W-1:0]        dout_q, dout_d;

    logic                     in_calc;
    logic [4:0]               coef_idx;
    logic                     mac_en, mac_clr, mac_neg;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [COEF_W-1:0] mac_b;
    logic signed [DATA_W-1:0] mac_y;

    assign dout = dout_q;

    // Steps 0..4 of a section are MACs (b0 x, b1 x1, b2 x2, -a1 y1, -a2 y2); step 5 commits.
    always_comb begin
        in_calc  = (phase_q != '0) && (phase_q <= PH_CALC_END);
        coef_idx = '0;
        if (step_q < 3'(MAC_STEPS)) begin
            coef_idx = 5'(sect_q) * 5'd5 + 5'(step_q);
        end
        mac_b = coef_q[coef_idx];
        case (step_q)
            3'd0:    mac_a = x_cur_q;
            3'd1:    mac_a = x1_q[sect_q];
            3'd2:    mac_a = x2_q[sect_q];
            3'd3:    mac_a = y1_q[sect_q];
            3'd4:    mac_a = y2_q[sect_q];
            default: mac_a = '0;
        endcase
        mac_en  = !c_we && in_calc && (step_q < 3'(MAC_STEPS));
        mac_clr = (step_q == 3'd0);
        mac_neg = (step_q >= 3'(A1));
    end

    always_comb begin
        phase_d = phase_q;
        step_d  = step_q;
        sect_d  = sect_q;
        coef_d  = coef_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        x_cur_d = x_cur_q;
        dout_d  = dout_q;
        if (c_we) begin
            phase_d = '0;
            step_d  = '0;
            sect_d  = '0;
            if (c_addr < 5'(NUM_COEF)) begin
                coef_d[c_addr] = c_in;
            end
        end else begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
            if (phase_q == '0) begin
                x_cur_d = {din, {(DATA_W - IN_W){1'b0}}};
                step_d  = '0;
                sect_d  = '0;
            end else if (in_calc) begin
                if (step_q == 3'(MAC_STEPS)) begin
                    step_d         = '0;
                    sect_d         = sect_q + SECT_W'(1);
                    x2_d[sect_q]   = x1_q[sect_q];
                    x1_d[sect_q]   = x_cur_q;
                    y2_d[sect_q]   = y1_q[sect_q];
                    y1_d[sect_q]   = mac_y;
                    x_cur_d        = mac_y;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            if (phase_q == PH_OUT) begin
                dout_d = x_cur_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            phase_q <= '0;
            step_q  <= '0;
            sect_q  <= '0;
            coef_q  <= '{default: '0};
            x1_q    <= '{default: '0};
            x2_q    <= '{default: '0};
            y1_q    <= '{default: '0};
            y2_q    <= '{default: '0};
            x_cur_q <= '0;
            dout_q  <= '0;
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
            sect_q  <= sect_d;
            coef_q  <= coef_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            x_cur_q <= x_cur_d;
            dout_q  <= dout_d;
        end
    end

    iir_mac u_mac (
        .clk    (clk),
        .nrst   (nrst),
        .en     (mac_en),
        .clr    (mac_clr),
        .neg    (mac_neg),
        .a      (mac_a),
        .b      (mac_b),
        .result (mac_y)
    );
endmodule

// File: tb/tb_iir_filter.sv
// Directed bench for iir_filter: impulse/step responses against hand-computed values.
module tb_iir_filter;
    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        c_we = 1'b0;
    logic [15:0] c_in = '0;
    logic [4:0]  c_addr = '0;
    logic [15:0] din = '0;
    logic [23:0] dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iir_filter dut (
        .clk    (clk),
        .nrst   (nrst),
        .c_we   (c_we),
        .c_in   (c_in),
        .c_addr (c_addr),
        .din    (din),
        .dout   (dout)
    );

    // All tasks start and end at a falling edge.
    task automatic check(input string tag, input logic [23:0] exp);
        checks++;
        assert (dout === exp) else begin
            errors++;
            $error("FAIL %s: dout=%h expected=%h", tag, dout, exp);
        end
    endtask

    task automatic do_reset();
        nrst = 1'b1;
        @(negedge clk);
        nrst = 1'b0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [15:0] val);
        c_we   = 1'b1;
        c_addr = addr;
        c_in   = val;
        @(negedge clk);
    endtask

    task automatic wr_done();
        c_we = 1'b0;
    endtask

    task automatic load_pass();
        for (int s = 0; s < 4; s++) wr(5'(5 * s), 16'h4000);
        wr_done();
    endtask

    task automatic load_recur(input logic [15:0] a1);
        wr(5'd0, 16'h4000);
        wr(5'd3, a1);
        for (int s = 1; s < 4; s++) wr(5'(5 * s), 16'h4000);
        wr_done();
    endtask

    task automatic run_check(input logic [15:0] v, input string tag, input logic [23:0] exp);
        din = v;
        repeat (52) @(negedge clk);
        check(tag, exp);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b0;
        check("reset_dout", 24'h000000);
        for (int i = 0; i < 10; i++) run_check(16'h0000, "idle", 24'h000000);

        // Pass-through with an exact latency probe around phase 25.
        do_reset();
        load_pass();
        din = 16'h8000;
        repeat (25) @(negedge clk);
        check("lat_pre", 24'h000000);
        @(negedge clk);
        check("lat_post", 24'h800000);
        repeat (26) @(negedge clk);
        for (int i = 0; i < 3; i++) run_check(16'h0000, "pass_tail", 24'h000000);

        // y = x + 0.5*y1 in section 0
        do_reset();
        load_recur(16'hE000);
        run_check(16'h8000, "recur0", 24'h800000);
        run_check(16'h0000, "recur1", 24'hC00000);
        run_check(16'h0000, "recur2", 24'hE00000);
        run_check(16'h0000, "recur3", 24'hF00000);
        run_check(16'h0000, "recur4", 24'hF80000);

        // y = x + y1 with a positive step must clamp, never wrap
        do_reset();
        load_recur(16'hC000);
        run_check(16'h7FFF, "sat0", 24'h7FFF00);
        run_check(16'h7FFF, "sat1", 24'h7FFFFF);
        run_check(16'h7FFF, "sat2", 24'h7FFFFF);
        run_check(16'h7FFF, "sat3", 24'h7FFFFF);

        // Out-of-range addresses must not disturb the map
        do_reset();
        load_pass();
        for (int a = 20; a < 32; a++) wr(5'(a), 16'h2000);
        wr_done();
        run_check(16'h8000, "oor_imp", 24'h800000);
        run_check(16'h0000, "oor_tail", 24'h000000);

        // Mid-period reset clears everything; a reload reproduces the response
        do_reset();
        load_recur(16'hE000);
        run_check(16'h8000, "pre_rst0", 24'h800000);
        run_check(16'h0000, "pre_rst1", 24'hC00000);
        din = 16'h0000;
        repeat (10) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("mid_rst", 24'h000000);
        nrst = 1'b0;
        load_recur(16'hE000);
        run_check(16'h8000, "post_rst0", 24'h800000);
        run_check(16'h0000, "post_rst1", 24'hC00000);
        run_check(16'h0000, "post_rst2", 24'hE00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
